andor_sweep_checker: RTL and testbench
======================================

# andor_sweep_checker

Self-checking stimulus sequencer for the AND/OR gate block (X = A & B, Y = B | C). It drives A/B/C through all eight input vectors and samples X/Y after a programmable settle time. It compares the samples against a golden model and reports mismatch count, first failing vector and pass/fail. It sits beside the gate block in the unit bench and in the on-chip self-test wrapper, acting as the driving/checking end of that gate's interface.

## Interface
- SETTLE_CYCLES, 1, idle cycles between driving a vector and sampling outputs (legal 0..15)
- REPEAT, 1, number of full 8-vector sweeps per run (legal 1..255)
- ERR_W, 8, width of the mismatch counter

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE only)
- abort  in  1  synchronous abort of a run in progress
- a_o, b_o, c_o  out  1  stimulus to gate inputs A, B, C
- x_i, y_i  in  1  gate outputs X, Y
- busy  out  1  high from run start until done or abort
- done  out  1  one-cycle pulse at run completion
- pass  out  1  err_count==0 at last completed run; held until next start
- err_count  out  ERR_W  mismatching vectors, saturating
- first_fail_vec  out  3  index of first mismatching vector of the run
- first_fail_valid  out  1  first_fail_vec is meaningful

## Operation
- Reset: FSM=IDLE; all outputs 0; vector/sweep/settle counters 0.
- Vector index v[2:0]: a_o=v[2], b_o=v[1], c_o=v[0]; registered outputs, change only when v changes.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: start=1 → DRIVE; v=0, sweep=0, err_count=0, first_fail_valid=0, pass=0, busy=1.
- DRIVE (1 cycle) → SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: stays exactly SETTLE_CYCLES cycles → CHECK.
- CHECK (1 cycle): mismatch if x_i≠(a_o&b_o) or y_i≠(b_o|c_o).
- Mismatch: err_count+1, saturating at 2^ERR_W−1, counted once per vector. On the first mismatch of the run: first_fail_vec=v, first_fail_valid=1.
- After CHECK: v=v+1 (7 wraps to 0). On wrap, sweep+1. sweep==REPEAT → DONE, else → DRIVE.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0 including this cycle's final check) → IDLE.
- start while busy: ignored.
- abort in any non-IDLE state: → IDLE next cycle; busy=0, done stays 0, pass=0, a_o/b_o/c_o=0; err_count and first_fail_* retained.
- abort and start in the same cycle in IDLE: start wins; abort is ignored.
- rst_n low mid-run: immediate return to reset values; no done.

## Timing
- Per vector: 2+SETTLE_CYCLES cycles.
- start sampled at edge 0 → done high in cycle 8·REPEAT·(2+SETTLE_CYCLES)+1.
- Default parameters: done high in cycle 25.
- Stimulus is stable from the DRIVE edge through CHECK inclusive. x_i/y_i are sampled at the CHECK edge and are treated as combinational from a_o/b_o/c_o.
- err_count and first_fail_* update at the edge ending CHECK; they are visible one cycle later.
- busy falls in the same cycle done rises.

## Structure
- Package andor_chk_pkg:
  - state enum
  - NUM_VECS=8, VEC_W=3
  - functions exp_x(v), exp_y(v) as the golden model
- No sub-module; a single FSM with counters. The gate block is instantiated by the wrapper/bench, not inside this block.

## Test plan
- Correct gate, defaults: start → done in cycle 25, pass=1, err_count=0, first_fail_valid=0.
- X stuck-at-0: mismatches at v=6,7 → err_count=2, first_fail_vec=6, pass=0.
- Y stuck-at-1, REPEAT=3: mismatches at v=0,4 per sweep → err_count=6, first_fail_vec=0.
- X inverted, ERR_W=2: 8 mismatches → err_count saturates at 3, no wrap.
- SETTLE_CYCLES=0 and 3: done in cycles 17 and 41; stimulus never changes between DRIVE and CHECK.
- abort at cycle 10, then rst_n low mid-second-run, start pulses while busy:
  - after abort: no done, busy=0, outputs 0, next start restarts from v=0
  - after reset: all outputs 0
  - start pulses while busy: no effect

Source files
------------

// File: rtl/andor_chk_pkg.sv
// Shared types and golden model for the AND/OR gate sweep checker.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, vector-space constants, and exp_x/exp_y, the
// reference behaviour of the gate under test (X = A & B, Y = B | C) with
// vector bit 2 = A, bit 1 = B, bit 0 = C.
package andor_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int NUM_VECS = 8;
  localparam int VEC_W    = 3;

  function automatic logic exp_x(input logic [VEC_W-1:0] v);
    return v[2] & v[1];
  endfunction

  function automatic logic exp_y(input logic [VEC_W-1:0] v);
    return v[1] | v[0];
  endfunction

endpackage

// File: rtl/andor_sweep_checker.sv
// Drives all 8 A/B/C vectors into an AND/OR gate, samples X/Y, counts mismatches.
// Latency: 2+SETTLE_CYCLES cycles per vector; done 8*REPEAT*(2+SETTLE_CYCLES)+1 cycles after start.
// Backpressure: none; start is ignored while busy, abort returns to idle next cycle.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, abort                   begin a run (idle only) / cancel a run in progress
//   a_o, b_o, c_o                  stimulus to gate inputs, decoded from the vector register
//   x_i, y_i                       gate outputs, treated as combinational from a_o/b_o/c_o
//   busy, done, pass               run in progress / completion pulse / last run clean
//   err_count                      mismatching vectors this run, saturating
//   first_fail_vec/_valid          index of the first mismatching vector of the run
module andor_sweep_checker
  import andor_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int REPEAT        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  input  logic             x_i,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [7:0]       REPEAT_LAST = 8'(REPEAT - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECS - 1);

  state_t           state;
  logic [VEC_W-1:0] v;
  logic [7:0]       sweep;
  logic [3:0]       settle_cnt;

  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Stimulus comes straight from the vector register, so it only moves when v does.
  assign a_o = v[2];
  assign b_o = v[1];
  assign c_o = v[0];

  assign mismatch = (x_i != exp_x(v)) || (y_i != exp_y(v));
  // Saturate rather than wrap so a large fault count never reads as a clean run.
  assign err_next = (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      v                <= '0;
      sweep            <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && abort) begin
        // Error history survives an abort so the partial run can be inspected.
        state      <= ST_IDLE;
        v          <= '0;
        sweep      <= '0;
        settle_cnt <= '0;
        busy       <= 1'b0;
        pass       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state            <= ST_DRIVE;
              v                <= '0;
              sweep            <= '0;
              settle_cnt       <= '0;
              busy             <= 1'b1;
              pass             <= 1'b0;
              err_count        <= '0;
              first_fail_vec   <= '0;
              first_fail_valid <= 1'b0;
            end
          end
          ST_DRIVE: begin
            settle_cnt <= '0;
            state      <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= ST_CHECK;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          ST_CHECK: begin
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= v;
              first_fail_valid <= 1'b1;
            end
            v <= v + 1'b1;
            if (v == LAST_VEC && sweep == REPEAT_LAST) begin
              // pass must include the check being retired on this very edge.
              state <= ST_DONE;
              sweep <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_next == '0);
            end else begin
              state <= ST_DRIVE;
              if (v == LAST_VEC) begin
                sweep <= sweep + 8'd1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_andor_sweep_checker.sv
// Bench for andor_sweep_checker: five instances with different parameters,
// each beside a behavioural AND/OR gate whose fault mode the bench selects.
module tb_andor_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] start, abort;
  logic [4:0] a, b, c, x, y;
  logic [4:0] busy, done, pass, ffv;
  logic [4:0][2:0] ffvec;
  logic [7:0] e0, e1, e2, e3;
  logic [1:0] e4;
  int         fm [5];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int pass;
    int err;
    int ffv;
    int ffvec;
    int changes;
    int gap;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  // Gate under test: 0 good, 1 X stuck-at-0, 2 Y stuck-at-1, 3 X inverted.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      x[i] = a[i] & b[i];
      y[i] = b[i] | c[i];
      case (fm[i])
        1: x[i] = 1'b0;
        2: y[i] = 1'b1;
        3: x[i] = ~(a[i] & b[i]);
        default: ;
      endcase
    end
  end

  andor_sweep_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .a_o(a[0]), .b_o(b[0]), .c_o(c[0]), .x_i(x[0]), .y_i(y[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(e0),
    .first_fail_vec(ffvec[0]), .first_fail_valid(ffv[0]));

  andor_sweep_checker #(.SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .a_o(a[1]), .b_o(b[1]), .c_o(c[1]), .x_i(x[1]), .y_i(y[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(e1),
    .first_fail_vec(ffvec[1]), .first_fail_valid(ffv[1]));

  andor_sweep_checker #(.SETTLE_CYCLES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .a_o(a[2]), .b_o(b[2]), .c_o(c[2]), .x_i(x[2]), .y_i(y[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(e2),
    .first_fail_vec(ffvec[2]), .first_fail_valid(ffv[2]));

  andor_sweep_checker #(.REPEAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]),
    .a_o(a[3]), .b_o(b[3]), .c_o(c[3]), .x_i(x[3]), .y_i(y[3]),
    .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(e3),
    .first_fail_vec(ffvec[3]), .first_fail_valid(ffv[3]));

  andor_sweep_checker #(.ERR_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[4]), .abort(abort[4]),
    .a_o(a[4]), .b_o(b[4]), .c_o(c[4]), .x_i(x[4]), .y_i(y[4]),
    .busy(busy[4]), .done(done[4]), .pass(pass[4]), .err_count(e4),
    .first_fail_vec(ffvec[4]), .first_fail_valid(ffv[4]));

  function automatic logic [31:0] get_err(input int i);
    case (i)
      0: return {24'd0, e0};
      1: return {24'd0, e1};
      2: return {24'd0, e2};
      3: return {24'd0, e3};
      default: return {30'd0, e4};
    endcase
  endfunction

  // Golden outcome of a run: walks every vector of every sweep against the faulty gate.
  function automatic exp_t model(input int f, input int rep, input int st, input int w);
    exp_t e;
    int   sat;
    int   av, bv, cv, ex, ey, gx, gy;
    sat     = (1 << w) - 1;
    e.err   = 0;
    e.ffv   = 0;
    e.ffvec = 0;
    for (int r = 0; r < rep; r++) begin
      for (int vv = 0; vv < 8; vv++) begin
        av = (vv >> 2) & 1;
        bv = (vv >> 1) & 1;
        cv = vv & 1;
        ex = av & bv;
        ey = bv | cv;
        gx = (f == 1) ? 0 : (f == 3) ? 1 - ex : ex;
        gy = (f == 2) ? 1 : ey;
        if (gx != ex || gy != ey) begin
          if (e.err < sat) e.err++;
          if (e.ffv == 0) begin
            e.ffv   = 1;
            e.ffvec = vv;
          end
        end
      end
    end
    e.pass    = (e.err == 0) ? 1 : 0;
    e.cyc     = 8 * rep * (2 + st) + 1;
    e.changes = 8 * rep;
    e.gap     = 2 + st;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input int i, input string tag);
    check({tag, "_busy"}, {31'd0, busy[i]}, 0);
    check({tag, "_done"}, {31'd0, done[i]}, 0);
    check({tag, "_pass"}, {31'd0, pass[i]}, 0);
    check({tag, "_abc"}, {29'd0, a[i], b[i], c[i]}, 0);
  endtask

  // One full run on instance i: expectation queued at start, compared when done appears.
  task automatic run(input int i, input int f, input int rep, input int st, input int w,
                     input bit glitch, input string tag);
    exp_t       g;
    int         cyc, changes, last, gap;
    logic [2:0] prev, abc;
    bit         got;
    fm[i] = f;
    sb.push_back(model(f, rep, st, w));
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
    cyc = 0; changes = 0; last = 0; gap = 1000; got = 0; prev = 3'b000;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start[i] = glitch && (cyc == 5 || cyc == 15);
      abc = {a[i], b[i], c[i]};
      if (abc !== prev) begin
        changes++;
        if (last != 0 && cyc - last < gap) gap = cyc - last;
        last = cyc;
        prev = abc;
      end
      if (done[i] === 1'b1) got = 1;
    end
    start[i] = 1'b0;
    g = sb.pop_front();
    check({tag, "_done_cycle"}, got ? cyc : -1, g.cyc);
    check({tag, "_busy_at_done"}, {31'd0, busy[i]}, 0);
    check({tag, "_pass"}, {31'd0, pass[i]}, g.pass);
    check({tag, "_err_count"}, get_err(i), g.err);
    check({tag, "_ff_valid"}, {31'd0, ffv[i]}, g.ffv);
    if (g.ffv != 0) check({tag, "_ff_vec"}, {29'd0, ffvec[i]}, g.ffvec);
    check({tag, "_stim_changes"}, changes, g.changes);
    check({tag, "_stim_min_gap"}, gap, g.gap);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    for (int i = 0; i < 5; i++) fm[i] = 0;
    repeat (3) @(negedge clk);
    check_idle_zero(0, "reset");
    check("reset_err", get_err(0), 0);
    check("reset_ffv", {31'd0, ffv[0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 0, 1, 1, 8, 1'b1, "good_glitch");
    run(0, 1, 1, 1, 8, 1'b0, "x_stuck0");
    run(3, 2, 3, 1, 8, 1'b0, "y_stuck1_rep3");
    run(4, 3, 1, 1, 2, 1'b0, "x_inv_errw2");
    run(1, 0, 1, 0, 8, 1'b0, "settle0");
    run(2, 0, 1, 3, 8, 1'b0, "settle3");

    // Abort in cycle 10 of a Y-stuck run (v=0 already failed), with a start pulse alongside.
    fm[0] = 2;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (10) @(negedge clk);
    abort[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    #1 begin
      abort[0] = 1'b0;
      start[0] = 1'b0;
    end
    @(negedge clk);
    check_idle_zero(0, "abort");
    check("abort_err_kept", get_err(0), 1);
    check("abort_ffv_kept", {31'd0, ffv[0]}, 1);
    check("abort_ffvec_kept", {29'd0, ffvec[0]}, 0);
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done[0] === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    run(0, 0, 1, 1, 8, 1'b0, "after_abort");

    // Reset mid-run once a mismatch has been recorded.
    fm[0] = 2;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (12) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_zero(0, "midrun_rst");
    check("midrun_rst_err", get_err(0), 0);
    check("midrun_rst_ffv", {31'd0, ffv[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, 1, 1, 8, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
